// File: rtl/instr_decoder_pkg.sv
// Shared definitions for the instruction decoder: opcode map, function-select
// codes, branch/writeback select codes and the packed datapath control word.
package instr_decoder_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_NOT  = 5'd5,
    OP_MOV  = 5'd6,
    OP_INC  = 5'd7,
    OP_DEC  = 5'd8,
    OP_ADI  = 5'd9,
    OP_ANDI = 5'd10,
    OP_ORI  = 5'd11,
    OP_LSL  = 5'd12,
    OP_LSR  = 5'd13,
    OP_LD   = 5'd14,
    OP_ST   = 5'd15,
    OP_LDI  = 5'd16,
    OP_SLT  = 5'd17,
    OP_BZ   = 5'd18,
    OP_BNZ  = 5'd19,
    OP_JMP  = 5'd20
  } opcode_e;

  typedef enum logic [3:0] {
    FS_PASS_A = 4'b0000,
    FS_INC    = 4'b0001,
    FS_ADD    = 4'b0010,
    FS_SUB    = 4'b0101,
    FS_DEC    = 4'b0110,
    FS_AND    = 4'b1000,
    FS_OR     = 4'b1001,
    FS_XOR    = 4'b1010,
    FS_NOT    = 4'b1011,
    FS_PASS_B = 4'b1100,
    FS_SHR    = 4'b1101,
    FS_SHL    = 4'b1110
  } fs_e;

  typedef enum logic [1:0] {
    BS_INC  = 2'b00,
    BS_COND = 2'b01,
    BS_JMP  = 2'b10
  } bs_e;

  typedef enum logic [1:0] {
    MD_FU  = 2'b00,
    MD_MEM = 2'b01,
    MD_SLT = 2'b10
  } md_e;

  typedef struct packed {
    logic [2:0] da;
    logic [2:0] aa;
    logic [2:0] ba;
    logic [1:0] bs;
    logic       ps;
    logic       mw;
    logic       rw;
    logic       ma;
    logic       mb;
    logic [1:0] md;
    logic [3:0] fs;
    logic [2:0] sh;
    logic       cs;
    logic       oe;
  } ctrl_t;

endpackage

// File: rtl/instr_decoder_ctrl_rom.sv
// Combinational opcode -> control word lookup.
//   instr_line : 17-bit instruction word
//   ctrl       : decoded control word (register fields always passed through)
module instr_decoder_ctrl_rom
  import instr_decoder_pkg::*;
(
  input  logic [16:0] instr_line,
  output ctrl_t       ctrl
);

  logic [4:0] opcode;
  assign opcode = instr_line[16:12];

  always_comb begin
    ctrl    = '0;
    ctrl.da = instr_line[11:9];
    ctrl.aa = instr_line[8:6];
    ctrl.ba = instr_line[5:3];
    ctrl.rw = 1'b1;
    case (opcode)
      OP_ADD:  ctrl.fs = FS_ADD;
      OP_SUB:  ctrl.fs = FS_SUB;
      OP_AND:  ctrl.fs = FS_AND;
      OP_OR:   ctrl.fs = FS_OR;
      OP_XOR:  ctrl.fs = FS_XOR;
      OP_NOT:  ctrl.fs = FS_NOT;
      OP_MOV:  ctrl.fs = FS_PASS_A;
      OP_INC:  ctrl.fs = FS_INC;
      OP_DEC:  ctrl.fs = FS_DEC;
      OP_ADI: begin
        ctrl.fs = FS_ADD;
        ctrl.mb = 1'b1;
        ctrl.cs = 1'b1;
      end
      OP_ANDI: begin
        ctrl.fs = FS_AND;
        ctrl.mb = 1'b1;
      end
      OP_ORI: begin
        ctrl.fs = FS_OR;
        ctrl.mb = 1'b1;
      end
      OP_LSL: begin
        ctrl.fs = FS_SHL;
        ctrl.sh = instr_line[2:0];
      end
      OP_LSR: begin
        ctrl.fs = FS_SHR;
        ctrl.sh = instr_line[2:0];
      end
      OP_LD: begin
        ctrl.fs = FS_PASS_A;
        ctrl.md = MD_MEM;
        ctrl.oe = 1'b1;
      end
      OP_ST: begin
        ctrl.fs = FS_PASS_A;
        ctrl.rw = 1'b0;
        ctrl.mw = 1'b1;
      end
      OP_LDI: begin
        ctrl.fs = FS_PASS_B;
        ctrl.mb = 1'b1;
      end
      OP_SLT: begin
        ctrl.fs = FS_SUB;
        ctrl.md = MD_SLT;
      end
      OP_BZ, OP_BNZ: begin
        ctrl.fs = FS_PASS_A;
        ctrl.rw = 1'b0;
        ctrl.bs = BS_COND;
        ctrl.ps = (opcode == OP_BNZ);
        ctrl.mb = 1'b1;
        ctrl.cs = 1'b1;
      end
      OP_JMP: begin
        ctrl.fs = FS_ADD;
        ctrl.rw = 1'b0;
        ctrl.bs = BS_JMP;
        ctrl.ma = 1'b1;
        ctrl.mb = 1'b1;
        ctrl.cs = 1'b1;
      end
      // Unassigned opcodes decode as NOP; register fields still pass through.
      default: ctrl.rw = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_decoder.sv
// Instruction decoder: registers the decoded control word, one cycle latency.
//   clk, rst   : rising-edge clock, synchronous active-high reset (all outputs 0)
//   instr_line : instruction word, sampled every cycle
//   DA/AA/BA   : register addresses
//   BS/PS      : branch select and polarity
//   MW/RW/OE   : memory write, register write, memory read enables
//   MA/MB/MD   : A-bus, B-bus and writeback mux selects
//   FS/SH/CS   : function select, shift amount, constant sign-extend
module instr_decoder
  import instr_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] instr_line,
  output logic [2:0]  DA,
  output logic [2:0]  AA,
  output logic [2:0]  BA,
  output logic [1:0]  BS,
  output logic        PS,
  output logic        MW,
  output logic        RW,
  output logic        MA,
  output logic        MB,
  output logic [1:0]  MD,
  output logic [3:0]  FS,
  output logic [2:0]  SH,
  output logic        CS,
  output logic        OE
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  instr_decoder_ctrl_rom u_rom (
    .instr_line (instr_line),
    .ctrl       (ctrl_d)
  );

  always_ff @(posedge clk) begin
    if (rst) ctrl_q <= '0;
    else     ctrl_q <= ctrl_d;
  end

  assign DA = ctrl_q.da;
  assign AA = ctrl_q.aa;
  assign BA = ctrl_q.ba;
  assign BS = ctrl_q.bs;
  assign PS = ctrl_q.ps;
  assign MW = ctrl_q.mw;
  assign RW = ctrl_q.rw;
  assign MA = ctrl_q.ma;
  assign MB = ctrl_q.mb;
  assign MD = ctrl_q.md;
  assign FS = ctrl_q.fs;
  assign SH = ctrl_q.sh;
  assign CS = ctrl_q.cs;
  assign OE = ctrl_q.oe;

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed scenarios plus randomized
// instructions/reset checked against a table-driven reference model.
module tb_instr_decoder;

  logic        clk;
  logic        rst;
  logic [16:0] instr_line;
  logic [2:0]  DA, AA, BA, SH;
  logic [1:0]  BS, MD;
  logic [3:0]  FS;
  logic        PS, MW, RW, MA, MB, CS, OE;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  instr_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .instr_line (instr_line),
    .DA (DA), .AA (AA), .BA (BA), .BS (BS), .PS (PS), .MW (MW), .RW (RW),
    .MA (MA), .MB (MB), .MD (MD), .FS (FS), .SH (SH), .CS (CS), .OE (OE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function-select per opcode 0..20, straight from the opcode map.
  int fs_tab [21] = '{4'b0010, 4'b0101, 4'b1000, 4'b1001, 4'b1010, 4'b1011,
                      4'b0000, 4'b0001, 4'b0110, 4'b0010, 4'b1000, 4'b1001,
                      4'b1110, 4'b1101, 4'b0000, 4'b0000, 4'b1100, 4'b0101,
                      4'b0000, 4'b0000, 4'b0010};

  // Expected outputs packed as {DA,AA,BA,BS,PS,MW,RW,MA,MB,MD,FS,SH,CS,OE}.
  function automatic logic [26:0] model(input logic [16:0] ins, input logic r);
    int op;
    logic [2:0] da, aa, ba, sh;
    logic [1:0] bs, md;
    logic [3:0] fs;
    logic ps, mw, rw, ma, mb, cs, oe;
    if (r) return '0;
    op = int'(ins[16:12]);
    da = ins[11:9];
    aa = ins[8:6];
    ba = ins[5:3];
    if (op > 20) return {da, aa, ba, 18'd0};
    fs = 4'(fs_tab[op]);
    rw = !(op == 15 || op == 18 || op == 19 || op == 20);
    mw = (op == 15);
    oe = (op == 14);
    md = (op == 14) ? 2'b01 : (op == 17) ? 2'b10 : 2'b00;
    bs = (op == 18 || op == 19) ? 2'b01 : (op == 20) ? 2'b10 : 2'b00;
    ps = (op == 19);
    ma = (op == 20);
    mb = (op inside {9, 10, 11, 16, 18, 19, 20});
    cs = (op inside {9, 18, 19, 20});
    sh = (op == 12 || op == 13) ? ins[2:0] : 3'd0;
    return {da, aa, ba, bs, ps, mw, rw, ma, mb, md, fs, sh, cs, oe};
  endfunction

  task automatic check(input string tag, input logic [26:0] got, input logic [26:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %07h expected %07h", tag, got, exp);
    end
  endtask

  // Apply one instruction/reset for one edge, then check just after the edge.
  task automatic step(input string tag, input logic [16:0] ins, input logic r);
    logic [26:0] got;
    instr_line = ins;
    rst        = r;
    @(posedge clk);
    #1;
    got = {DA, AA, BA, BS, PS, MW, RW, MA, MB, MD, FS, SH, CS, OE};
    check(tag, got, model(ins, r));
  endtask

  function automatic logic [16:0] mk(input int op, input logic [2:0] imm);
    logic [4:0] o;
    o = 5'(op);
    return {o, 3'b001, 3'b010, 3'b011, imm};
  endfunction

  initial begin
    logic [16:0] ins;
    logic        r;

    // Reset dominates an all-ones instruction.
    step("rst0", 17'h1FFFF, 1'b1);
    step("rst1", 17'h1FFFF, 1'b1);
    step("first_add", 17'b00000_001_010_011_000, 1'b0);

    // Opcode sweep 0..20, one per clock.
    for (int op = 0; op <= 20; op++)
      step($sformatf("sweep_op%0d", op), mk(op, 3'b000), 1'b0);

    step("lsl_imm5", 17'b01100_001_010_011_101, 1'b0);
    step("lsr_imm7", mk(13, 3'b111), 1'b0);
    step("ld", mk(14, 3'b000), 1'b0);
    step("st", mk(15, 3'b000), 1'b0);
    step("bnz", mk(19, 3'b110), 1'b0);
    step("jmp", mk(20, 3'b001), 1'b0);
    step("adi", mk(9, 3'b100), 1'b0);
    step("andi", mk(10, 3'b100), 1'b0);
    step("nop21", mk(21, 3'b101), 1'b0);
    step("nop31", {5'd31, 3'b111, 3'b101, 3'b010, 3'b110}, 1'b0);

    // Mid-stream reset while LD is presented, then resume.
    step("pre_rst_add", mk(0, 3'b000), 1'b0);
    step("rst_on_ld", mk(14, 3'b000), 1'b1);
    step("post_rst_ld", mk(14, 3'b000), 1'b0);
    step("post_rst_sub", mk(1, 3'b010), 1'b0);

    // Randomized instructions over the full opcode space, occasional reset.
    for (int i = 0; i < 400; i++) begin
      ins = 17'($urandom);
      r   = ($urandom_range(0, 15) == 0);
      step($sformatf("rand%0d_op%0d", i, ins[16:12]), ins, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/instr_decoder.md
Name: instr_decoder

Overview:
- Decodes one 17-bit instruction word into the datapath control word: register addresses, ALU/shifter function, operand/result mux selects, memory and branch controls.
- Sits between instruction fetch and the register file/function unit stage.
- Outputs are registered, with one cycle of latency.
- Instruction fields: opcode = instr_line[16:12], DA = [11:9], AA = [8:6], BA = [5:3], imm/SH = [2:0].

Parameters:
- none (widths fixed by ISA)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr_line  in  17  instruction word
- DA  out  3  destination register
- AA  out  3  A-source register
- BA  out  3  B-source register
- BS  out  2  branch select: 00 PC+1, 01 conditional, 10 unconditional jump, 11 reserved
- PS  out  1  branch polarity: 0 = take if zero, 1 = take if nonzero
- MW  out  1  memory write enable
- RW  out  1  register-file write enable
- MA  out  1  A-bus mux: 0 = R[AA], 1 = PC
- MB  out  1  B-bus mux: 0 = R[BA], 1 = constant
- MD  out  2  writeback select: 00 function unit, 01 memory data, 10 SLT status bit, 11 reserved
- FS  out  4  function select
- SH  out  3  shift amount
- CS  out  1  constant fill: 0 = zero-extend imm, 1 = sign-extend imm
- OE  out  1  memory output (read) enable

Behaviour:
- All outputs registered; value at edge N reflects instr_line sampled at edge N. Latency = 1 clk. No handshake.
- rst=1 at an edge: every output = 0 (a NOP: RW=MW=OE=0, BS=00). Reset dominates the instruction input.
- DA/AA/BA always copy their fields, for every opcode including NOPs.
- SH = instr_line[2:0] for LSL/LSR; 0 otherwise.
- Defaults, unless listed per opcode: RW=1, MW=0, OE=0, BS=00, PS=0, MA=0, MB=0, MD=00, CS=0.
- FS codes: 0000 pass A, 0001 A+1, 0010 A+B, 0101 A-B, 0110 A-1, 1000 AND, 1001 OR, 1010 XOR, 1011 NOT A, 1100 pass B, 1101 SHR, 1110 SHL.
- Opcode map:
  - 0 ADD: FS=0010
  - 1 SUB: FS=0101
  - 2 AND: FS=1000
  - 3 OR: FS=1001
  - 4 XOR: FS=1010
  - 5 NOT: FS=1011
  - 6 MOV: FS=0000
  - 7 INC: FS=0001
  - 8 DEC: FS=0110
  - 9 ADI: FS=0010, MB=1, CS=1
  - 10 ANDI: FS=1000, MB=1
  - 11 ORI: FS=1001, MB=1
  - 12 LSL: FS=1110, SH=imm
  - 13 LSR: FS=1101, SH=imm
  - 14 LD: MD=01, OE=1, FS=0000
  - 15 ST: RW=0, MW=1, FS=0000
  - 16 LDI: FS=1100, MB=1
  - 17 SLT: FS=0101, MD=10
  - 18 BZ: RW=0, BS=01, PS=0, MB=1, CS=1, FS=0000
  - 19 BNZ: as BZ with PS=1
  - 20 JMP: RW=0, BS=10, MA=1, MB=1, CS=1, FS=0010
- Opcodes 21–31: NOP. RW=MW=OE=0, BS=00, all other controls 0; DA/AA/BA still copied.
- A new instruction every cycle is accepted; back-to-back changes each appear exactly one cycle later.

Decomposition:
- Shared package: 5-bit opcode constants (OP_ADD..OP_JMP), FS codes, BS codes (BS_INC/BS_COND/BS_JMP), MD codes (MD_FU/MD_MEM/MD_SLT), and a packed control-word typedef.
- Optional sub-module instr_ctrl_rom: purely combinational opcode -> control word. instr_decoder wraps it with the output register and reset.

Test Plan:
- Assert rst for 2 clks while instr_line=17'h1FFFF -> all outputs 0. Release rst, apply 17'b00000_001_010_011_000 -> next clk DA=1, AA=2, BA=3, FS=0010, RW=1, all other controls 0.
- Sweep opcodes 0..20 with fields 001/010/011/000, one per clk -> each cycle matches the opcode map. DA/AA/BA stay 1/2/3. ST, BZ, BNZ and JMP give RW=0.
- LSL with imm=101 (17'b01100_001_010_011_101) -> FS=1110, SH=5. LD -> MD=01, OE=1, RW=1. ST -> MW=1, OE=0.
- BNZ (opcode 19) -> BS=01, PS=1, MB=1, CS=1. JMP (opcode 20) -> BS=10, MA=1. ADI -> CS=1, MB=1. ANDI -> CS=0, MB=1.
- Opcodes 21 and 31 -> NOP controls, with DA/AA/BA still passed through.
- rst asserted mid-sweep while opcode=14 -> next clk all outputs 0. After deassert, decode resumes with one-cycle latency.
